clk_div_scheduler: RTL and testbench
====================================

// Module: clk_div_scheduler
// PURPOSE
//   Multi-channel programmable clock-divider controller. Generates NCH divided
//   clock-enable waveforms and period strobes from one input clock. Divisors are
//   reconfigured via a valid/ready port, applied only at period boundaries so no
//   output ever shows a runt pulse. Sits between system config logic and the
//   blocks consuming divided clocks/enables.
// PARAMETERS
//   NCH      2  number of divider channels
//   CHW      1  channel-select width (>= clog2(NCH), min 1)
//   CW       8  divisor/counter width
//   DEF_DIV  4  divisor loaded at reset, all channels (2..2^CW-1)
// PORTS
//   clk_in     in   1        single clock; all logic on posedge
//   reset      in   1        synchronous, active-high
//   cfg_valid  in   1        divisor write request
//   cfg_ch     in   CHW      target channel; values >= NCH ignored (accepted, dropped)
//   cfg_div    in   CW       requested divisor
//   cfg_ready  out  1        write accepted this cycle if cfg_valid also high
//   clk_out    out  NCH      divided waveform per channel, registered
//   tick       out  NCH      1-cycle strobe, first cycle of each period, registered
//   busy       out  NCH      divisor update pending on channel
// BEHAVIOUR
//   - Reset (sync, highest priority): cnt=DEF_DIV-1, div=DEF_DIV, pend=0;
//     clk_out=0, tick=0, busy=0; cfg_ready=0 while reset high.
//   - Per channel counter cnt: cnt==div-1 -> 0 (period boundary), else +1.
//   - half = div>>1. clk_out=1 when cnt<half: high floor(div/2), low ceil(div/2)
//     cycles. tick=1 exactly when cnt==0. Both registered, consistent with cnt.
//   - First edge after reset release: cnt=0, clk_out=1, tick=1.
//   - Handshake: cfg_ready = ~reset & (cfg_ch>=NCH | ~pend[cfg_ch]), combinational.
//     Transfer on cfg_valid & cfg_ready: pend_div<=cfg_div, pend<=1.
//   - Clamp: cfg_div of 0 or 1 stored as 2.
//   - Apply: at the edge where cnt wraps to 0 with pend=1: div<=pend_div,
//     pend<=0; new period uses new div from that cycle (cnt=0 uses new half).
//   - Write accepted on a wrap edge is NOT applied at that edge; it applies at
//     the next boundary (one full old period later).
//   - Second write to a pending channel: cfg_ready=0; master must hold; pending
//     value never overwritten.
//   - busy[ch]=pend[ch]; falls the cycle the new period starts.
//   - Rewrite of the current divisor is legal; period unchanged, busy cycles 1->0.
//   - Channels fully independent; no arbitration beyond one write per cycle.
// CONFIGURATION
//   CLKDIV_PHASE_SYNC_EN defined: extra input port sync (1 bit). sync=1 at an edge
//     (reset low): every channel applies pending divisor immediately, pend<=0,
//     cnt<=0, clk_out<=1, tick<=1 - all channels phase-aligned. A write accepted
//     the same edge becomes pending, not applied. Priority: reset > sync > wrap.
//   Undefined: no sync port; channels phase only from reset release.
// TESTING  (NCH=2, CW=8, DEF_DIV=4)
//   1 release reset, no writes -> clk_out[0],[1] = 1,1,0,0 repeating; tick every
//     4th cycle aligned with clk_out rising; busy=0.
//   2 write ch1 div=6 at cnt=1 -> busy[1]=1, cfg_ready=0 for ch1; after current
//     period ends clk_out[1]=1,1,1,0,0,0; busy[1] drops at that boundary; ch0 untouched.
//   3 write div=3 -> 1 high/2 low; write div=0 and div=1 -> both behave as div=2
//     (1 high/1 low, tick every 2 cycles).
//   4 write ch0 div=8 then hold cfg_valid with div=5 -> second held (ready=0)
//     until boundary; div=8 period runs once, then div=5 applied next boundary.
//   5 reset asserted mid-period with ch1 pending -> next cycle all outputs 0,
//     busy=0; release -> DEF_DIV pattern restarts, pending value lost.
//   6 (CLKDIV_PHASE_SYNC_EN) ch0 div=4, ch1 div=6 running skewed, pulse sync ->
//     both tick=1, clk_out=1 next cycle; pending divisors take effect there.

Source files
------------

// File: rtl/clk_div_scheduler.sv
// clk_div_scheduler: multi-channel divided clock enables with boundary-synchronised divisor updates.
// Optional CLKDIV_PHASE_SYNC_EN adds a sync input that phase-aligns every channel.
module clk_div_scheduler #(
   parameter int NCH     = 2,
   parameter int CHW     = 1,
   parameter int CW      = 8,
   parameter int DEF_DIV = 4
) (
   input  logic           clk_in,
   input  logic           reset,
`ifdef CLKDIV_PHASE_SYNC_EN
   input  logic           sync,
`endif
   input  logic           cfg_valid,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   output logic           cfg_ready,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] busy
);
   logic                  sync_i;
   logic [NCH-1:0]        pend;
   logic [(1<<CHW)-1:0]   pend_x;
   logic                  accept;
   logic [CW-1:0]         cfg_div_c;
`ifdef CLKDIV_PHASE_SYNC_EN
   assign sync_i = sync;
`else
   assign sync_i = 1'b0;
`endif
   // channels beyond NCH read as never pending, so their writes are accepted and dropped
   always_comb begin
      pend_x = '0;
      pend_x[NCH-1:0] = pend;
   end
   assign cfg_ready = ~reset & ~pend_x[cfg_ch];
   assign accept    = cfg_valid & cfg_ready;
   assign cfg_div_c = (cfg_div < CW'(2)) ? CW'(2) : cfg_div;
   assign busy      = pend;
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [CW-1:0] cnt, div, pdiv, cnt_n, div_n;
      logic          p, co, tk, bound, wr;
      always_comb begin
         bound = (cnt == div - 1'b1) | sync_i;
         wr    = accept & (cfg_ch == CHW'(c));
         cnt_n = bound ? '0 : cnt + 1'b1;
         div_n = (bound & p) ? pdiv : div;
      end
      // outputs are computed from the next count/divisor so they line up with cnt
      always_ff @(posedge clk_in) begin
         if (reset) begin
            cnt  <= CW'(DEF_DIV - 1);
            div  <= CW'(DEF_DIV);
            pdiv <= CW'(DEF_DIV);
            p    <= 1'b0;
            co   <= 1'b0;
            tk   <= 1'b0;
         end else begin
            cnt  <= cnt_n;
            div  <= div_n;
            co   <= cnt_n < (div_n >> 1);
            tk   <= cnt_n == '0;
            p    <= wr | (p & ~bound);
            if (wr) pdiv <= cfg_div_c;
         end
      end
      assign pend[c]    = p;
      assign clk_out[c] = co;
      assign tick[c]    = tk;
   end
endmodule

// File: tb/tb_clk_div_scheduler.sv
// tb_clk_div_scheduler: randomized and directed stimulus against a period-start reference model.
module tb_clk_div_scheduler;
   localparam int NCH = 2, CHW = 2, CW = 8, DEF = 4;
   logic           clk_in = 1'b0, reset = 1'b1, cfg_valid = 1'b0, sync = 1'b0;
   logic [CHW-1:0] cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           cfg_ready;
   logic [NCH-1:0] clk_out, tick, busy;
   int   n_chk = 0, n_err = 0;
   int   cyc = 0;
   int   start[NCH], d[NCH], pd[NCH];
   bit   pend[NCH];
   bit   in_rst = 1'b1;

   clk_div_scheduler #(.NCH(NCH), .CHW(CHW), .CW(CW), .DEF_DIV(DEF)) dut (
      .clk_in(clk_in), .reset(reset),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync(sync),
`endif
      .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .busy(busy));

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // model: a period starts at cycle start[c] and lasts d[c] cycles; position = cyc - start
   task automatic cycle(input bit rst, input bit v, input int ch, input int dv, input bit s);
      bit exp_ready, acc, s_eff;
      int pos;
      reset = rst; cfg_valid = v; cfg_ch = CHW'(ch); cfg_div = CW'(dv);
`ifdef CLKDIV_PHASE_SYNC_EN
      s_eff = s;
`else
      s_eff = 1'b0;
`endif
      sync = s_eff;
      #1;
      exp_ready = !rst && (ch >= NCH || !pend[ch]);
      check("cfg_ready", cfg_ready, exp_ready);
      acc = v && exp_ready && ch < NCH;
      cyc++;
      if (rst) begin
         in_rst = 1'b1;
         for (int c = 0; c < NCH; c++) begin pend[c] = 0; d[c] = DEF; end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (in_rst || s_eff || cyc - start[c] == d[c]) begin
               start[c] = cyc;
               if (pend[c]) begin d[c] = pd[c]; pend[c] = 0; end
            end
            if (acc && ch == c) begin pend[c] = 1; pd[c] = (dv < 2) ? 2 : dv; end
         end
         in_rst = 1'b0;
      end
      @(posedge clk_in);
      #1;
      for (int c = 0; c < NCH; c++) begin
         pos = cyc - start[c];
         check($sformatf("clk_out%0d", c), clk_out[c], in_rst ? 0 : (pos < d[c] / 2));
         check($sformatf("tick%0d", c), tick[c], in_rst ? 0 : (pos == 0));
         check($sformatf("busy%0d", c), busy[c], in_rst ? 0 : pend[c]);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   initial begin
      @(posedge clk_in); #1;
      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 1, 9, 0);
      idle(9);
      cycle(0, 1, 1, 6, 0);
      cycle(0, 1, 1, 7, 0);
      idle(14);
      cycle(0, 1, 0, 3, 0);
      idle(8);
      cycle(0, 1, 1, 0, 0);
      idle(6);
      cycle(0, 1, 1, 1, 0);
      idle(6);
      cycle(0, 1, 0, 8, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 5, 0);
      idle(12);
      cycle(0, 1, 1, 6, 0);
      cycle(0, 1, 2, 9, 0);
      cycle(0, 1, 3, 9, 0);
      cycle(0, 1, 1, 7, 0);
      idle(2);
      cycle(1, 0, 0, 0, 0);
      idle(10);
      cycle(0, 1, 1, 6, 0);
      idle(5);
      cycle(0, 1, 0, 3, 0);
      cycle(0, 0, 0, 0, 1);
      idle(10);
      for (int i = 0; i < 5000; i++)
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 9),
               $urandom_range(0, 59) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
